btn_event_sched: RTL and testbench

BTN_EVENT_SCHED -- requirements
Module: btn_event_sched

---
 rtl/btn_event_sched.sv | 177 +++++++++++++++++
 tb/tb_btn_event_sched.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/btn_event_sched.sv
// btn_event_sched: per-button press/auto-repeat event capture with a
// round-robin, start-triggered grant FSM. Each start request yields exactly
// one done pulse two cycles later carrying {valid, repeat, idx}.
module btn_event_sched #(
  parameter logic [15:0] REPEAT_DELAY = 16'd1000,
  parameter logic [15:0] REPEAT_RATE  = 16'd250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_port,
  input  logic [3:0] btn_stable,
  output logic       done_port,
  output logic [3:0] out1
);

  // Held count at which a repeat fires, and where the count restarts after one
  localparam logic [15:0] RPT_FIRE   = REPEAT_DELAY - 16'd1;
  localparam logic [15:0] RPT_RELOAD = REPEAT_DELAY - REPEAT_RATE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Registered state
  state_t      state_q,   state_d;
  logic [1:0]  ptr_q,     ptr_d;
  logic [3:0]  prev_q,    prev_d;
  logic [3:0]  pending_q, pending_d;
  logic [3:0]  tag_q,     tag_d;
  logic [3:0]  drop_q,    drop_d;
  logic        done_q,    done_d;
  logic [3:0]  out1_q,    out1_d;
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];

  // Combinational helpers
  logic [3:0]  press_s;
  logic [3:0]  held_s;
  logic [3:0]  rpt_s;
  logic [3:0]  evt_s;
  logic [3:0]  clr_s;
  logic        found_s;
  logic [1:0]  gnt_idx_s;

  // Edge detection against the registered previous level
  always_comb begin
    press_s = btn_stable & ~prev_q;
    held_s  = btn_stable & prev_q;
    prev_d  = btn_stable;
  end

  // Hold counters: the press cycle counts as held count 0, so the counter
  // loads 1 on a press; a repeat fires at RPT_FIRE and reloads RPT_RELOAD
  always_comb begin
    cnt_d = cnt_q;
    rpt_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (held_s[i] && (cnt_q[i] == RPT_FIRE)) begin
        rpt_s[i] = 1'b1;
      end else begin
        rpt_s[i] = 1'b0;
      end
      if (!btn_stable[i]) begin
        cnt_d[i] = 16'd0;
      end else if (press_s[i]) begin
        cnt_d[i] = 16'd1;
      end else if (rpt_s[i]) begin
        cnt_d[i] = RPT_RELOAD;
      end else if (cnt_q[i] == 16'hFFFF) begin
        cnt_d[i] = cnt_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // Round-robin search for the first pending button starting at ptr
  always_comb begin
    logic [1:0] cand;
    found_s   = 1'b0;
    gnt_idx_s = ptr_q;
    cand      = ptr_q;
    for (int off = 0; off < 4; off++) begin
      cand = ptr_q + 2'(off);
      if (!found_s && pending_q[cand]) begin
        found_s   = 1'b1;
        gnt_idx_s = cand;
      end else begin
        found_s   = found_s;
        gnt_idx_s = gnt_idx_s;
      end
    end
  end

  // Pending/tag/drop bookkeeping; a new event wins over the grant clear,
  // and an event landing on the cycle its button is served is not a drop
  always_comb begin
    evt_s = press_s | rpt_s;
    if ((state_q == ARB) && found_s) begin
      clr_s = 4'b0001 << gnt_idx_s;
    end else begin
      clr_s = 4'b0000;
    end
    pending_d = (pending_q & ~clr_s) | evt_s;
    tag_d     = rpt_s | (tag_q & ~evt_s);
    drop_d    = drop_q | (evt_s & pending_q & ~clr_s);
  end

  // Grant FSM next-state and registered-output values
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    out1_d  = out1_q;
    case (state_q)
      IDLE: begin
        if (start_port) begin
          state_d = ARB;
        end else begin
          state_d = IDLE;
        end
      end
      ARB: begin
        state_d = DONE;
        done_d  = 1'b1;
        if (found_s) begin
          out1_d = {1'b1, tag_q[gnt_idx_s], gnt_idx_s};
          ptr_d  = gnt_idx_s + 2'd1;
        end else begin
          out1_d = 4'b0000;
          ptr_d  = ptr_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state updates, synchronous active-high reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      prev_q    <= 4'b0000;
      pending_q <= 4'b0000;
      tag_q     <= 4'b0000;
      drop_q    <= 4'b0000;
      done_q    <= 1'b0;
      out1_q    <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 16'd0;
      end
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      tag_q     <= tag_d;
      drop_q    <= drop_d;
      done_q    <= done_d;
      out1_q    <= out1_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign done_port = done_q;
  assign out1      = out1_q;

endmodule

// File: tb/tb_btn_event_sched.sv
// Directed bench for btn_event_sched: one default-parameter instance for
// arbitration/reset cases, one fast-repeat instance for repeat timing.
module tb_btn_event_sched;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_a, start_b;
  logic [3:0] btn_a, btn_b;
  logic       done_a, done_b;
  logic [3:0] out1_a, out1_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  btn_event_sched dut_a (
    .clock      (clock),
    .reset      (reset),
    .start_port (start_a),
    .btn_stable (btn_a),
    .done_port  (done_a),
    .out1       (out1_a)
  );

  btn_event_sched #(.REPEAT_DELAY(16'd10), .REPEAT_RATE(16'd4)) dut_b (
    .clock      (clock),
    .reset      (reset),
    .start_port (start_b),
    .btn_stable (btn_b),
    .done_port  (done_b),
    .out1       (out1_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic next();
    @(posedge clock);
    #1;
  endtask

  // One start request: ARB cycle (no pulse), DONE cycle (pulse + out1), back to IDLE (out1 held)
  task automatic serve(input bit use_b, input logic [3:0] exp, input string tag);
    if (use_b) start_b = 1'b1;
    else       start_a = 1'b1;
    next();
    start_a = 1'b0;
    start_b = 1'b0;
    chk({tag, "_arb_nodone"}, use_b ? done_b : done_a, 16'd0);
    next();
    chk({tag, "_done"}, use_b ? done_b : done_a, 16'd1);
    chk({tag, "_out1"}, use_b ? out1_b : out1_a, {12'd0, exp});
    next();
    chk({tag, "_done_low"}, use_b ? done_b : done_a, 16'd0);
    chk({tag, "_out1_hold"}, use_b ? out1_b : out1_a, {12'd0, exp});
  endtask

  initial begin
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    btn_a   = 4'b0000;
    btn_b   = 4'b0000;
    repeat (3) next();
    chk("rst_done",    done_a, 16'd0);
    chk("rst_out1",    out1_a, 16'd0);
    chk("rst_state",   16'(dut_a.state_q), 16'd0);
    chk("rst_ptr",     dut_a.ptr_q, 16'd0);
    chk("rst_pending", dut_a.pending_q, 16'd0);
    chk("rst_drop",    dut_a.drop_q, 16'd0);
    chk("rst_done_b",  done_b, 16'd0);
    chk("rst_out1_b",  out1_b, 16'd0);
    reset = 1'b0;
    next();

    // Single press of button 2, then a valid and an empty grant
    btn_a = 4'b0100;
    next();
    chk("p27_pending", dut_a.pending_q, 16'h4);
    repeat (4) next();
    serve(1'b0, 4'b1010, "p27_first");
    chk("p27_ptr", dut_a.ptr_q, 16'd3);
    serve(1'b0, 4'b0000, "p27_second");
    chk("p27_ptr_kept", dut_a.ptr_q, 16'd3);
    btn_a = 4'b0000;
    next();

    // Buttons 0 and 3 together, round robin from ptr 0
    reset = 1'b1;
    next();
    reset = 1'b0;
    btn_a = 4'b1001;
    next();
    chk("p28_pending", dut_a.pending_q, 16'h9);
    chk("p28_ptr0", dut_a.ptr_q, 16'd0);
    serve(1'b0, 4'b1000, "p28_g0");
    chk("p28_ptr1", dut_a.ptr_q, 16'd1);
    serve(1'b0, 4'b1011, "p28_g3");
    serve(1'b0, 4'b0000, "p28_none");
    chk("p28_ptr_wrap", dut_a.ptr_q, 16'd0);
    btn_a = 4'b0000;
    next();

    // Double press of button 2 before any start -> drop and single grant
    btn_a = 4'b0100;
    next();
    btn_a = 4'b0000;
    next();
    chk("p30_nodrop", dut_a.drop_q, 16'd0);
    btn_a = 4'b0100;
    next();
    chk("p30_drop", dut_a.drop_q, 16'h4);
    chk("p30_pending", dut_a.pending_q, 16'h4);
    btn_a = 4'b0000;
    next();
    serve(1'b0, 4'b1010, "p30_grant");
    serve(1'b0, 4'b0000, "p30_none");
    chk("p30_drop_sticky", dut_a.drop_q, 16'h4);

    // Reset during ARB aborts the grant
    btn_a = 4'b0010;
    next();
    btn_a = 4'b0000;
    serve(1'b0, 4'b1001, "p31_pre");
    chk("p31_ptr_pre", dut_a.ptr_q, 16'd2);
    btn_a = 4'b0001;
    next();
    btn_a   = 4'b0000;
    start_a = 1'b1;
    next();
    start_a = 1'b0;
    chk("p31_in_arb", 16'(dut_a.state_q), 16'd1);
    reset = 1'b1;
    next();
    chk("p31_done",    done_a, 16'd0);
    chk("p31_state",   16'(dut_a.state_q), 16'd0);
    chk("p31_ptr",     dut_a.ptr_q, 16'd0);
    chk("p31_out1",    out1_a, 16'd0);
    chk("p31_pending", dut_a.pending_q, 16'd0);
    reset = 1'b0;
    next();
    chk("p31_done_after", done_a, 16'd0);
    chk("p31_out1_after", out1_a, 16'd0);

    // Auto-repeat: delay 10, rate 4, button 1 held 30 cycles
    btn_b = 4'b0010;
    next();
    serve(1'b1, 4'b1001, "p29_press");
    repeat (6) next();
    serve(1'b1, 4'b1101, "p29_rpt9");
    for (int r = 1; r < 6; r++) begin
      next();
      if (r == 5) btn_b = 4'b0000;
      else        btn_b = 4'b0010;
      serve(1'b1, 4'b1101, "p29_rpt");
    end
    serve(1'b1, 4'b0000, "p29_none");
    chk("p29_nodrop", dut_b.drop_q, 16'd0);

    // Repeat of button 0 lands in the cycle its press is granted
    btn_b = 4'b0001;
    next();
    repeat (7) next();
    serve(1'b1, 4'b1000, "p32_press");
    chk("p32_pending0", 16'(dut_b.pending_q[0]), 16'd1);
    serve(1'b1, 4'b1100, "p32_rpt");
    btn_b = 4'b0000;
    next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
